// File: rtl/demux_burst_sched.sv
// Round-robin burst scheduler for a 1-to-8 demultiplexer.
// A single valid/ready stream is steered to one of eight channels. Each grant
// carries up to BURST_LEN words, and then the grant rotates to the next enabled
// channel. A one-word holding register feeds all channels. Only the granted
// channel sees out_valid.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no grant; holding register empty, waiting for the first word
// BURST | channel sel granted; words flow until count/mask closes it
module demux_burst_sched #(
   parameter  int DATA_W    = 8,
   parameter  int BURST_LEN = 4,
   localparam int CNT_W     = $clog2(BURST_LEN + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   input  logic [7:0]        mask,
   output logic [7:0]        out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic [7:0]        out_ready,
   output logic [2:0]        cur_sel,
   output logic              burst_active
);

   typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

   state_t            state, state_nxt;
   logic              hold_valid;
   logic [DATA_W-1:0] hold_data;
   logic [2:0]        sel, ptr, pick;
   logic [CNT_W-1:0]  acc_cnt;
   logic              accept, fire, cnt_full, burst_close;

   assign accept   = in_valid & in_ready;
   assign fire     = hold_valid & out_ready[sel];
   assign cnt_full = (acc_cnt == CNT_W'(BURST_LEN));

   // A burst ends when its last word leaves, or when the granted channel is
   // disabled and nothing remains to deliver.
   assign burst_close = (state == BURST) &
                        ((fire & ~accept & (cnt_full | ~mask[sel])) |
                         (~hold_valid & ~mask[sel]));

   // Rotating priority: the first enabled channel at or after ptr, wrapping mod 8.
   always_comb begin
      pick = ptr;
      for (int i = 7; i >= 0; i--) begin
         if (mask[ptr + 3'(i)]) pick = ptr + 3'(i);
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept)      state_nxt = BURST;
         BURST:   if (burst_close) state_nxt = IDLE;
         default:                  state_nxt = IDLE;
      endcase
   end

   // Output logic. in_ready uses registered state, mask and out_ready[sel] only.
   always_comb begin
      in_ready     = 1'b0;
      burst_active = (state == BURST);
      if (!rst) begin
         case (state)
            IDLE:    in_ready = ~hold_valid & (|mask);
            BURST:   in_ready = (~hold_valid | fire) & mask[sel] &
                                (acc_cnt < CNT_W'(BURST_LEN));
            default: in_ready = 1'b0;
         endcase
      end
   end

   // Holding register, channel select, rotation pointer and burst counter
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_valid <= 1'b0;
         hold_data  <= '0;
         sel        <= '0;
         ptr        <= '0;
         acc_cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  sel        <= pick;
                  hold_data  <= in_data;
                  hold_valid <= 1'b1;
                  acc_cnt    <= CNT_W'(1);
               end
            end
            BURST: begin
               if (accept) begin
                  hold_data  <= in_data;
                  hold_valid <= 1'b1;
                  acc_cnt    <= acc_cnt + CNT_W'(1);
               end else if (fire) begin
                  hold_valid <= 1'b0;
               end
               if (burst_close) begin
                  ptr     <= sel + 3'd1;
                  acc_cnt <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   // One-hot valid decoded from the registered select and holding flag.
   always_comb begin
      out_valid = hold_valid ? (8'h01 << sel) : 8'h00;
   end

   assign out_data = hold_data;
   assign cur_sel  = sel;

endmodule

// File: tb/tb_demux_burst_sched.sv
// Bench for demux_burst_sched: a table of idle/reset vectors, plus hand-written
// sequences for streaming, mask skip and wrap, backpressure, mid-burst disable,
// an all-zero mask, and reset during a burst. Accepted words go into a
// scoreboard along with the channel that should receive them.
module tb_demux_burst_sched;
   localparam int DATA_W    = 8;
   localparam int BURST_LEN = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic [7:0]        mask;
   logic [7:0]        out_valid;
   logic [DATA_W-1:0] out_data;
   logic [7:0]        out_ready;
   logic [2:0]        cur_sel;
   logic              burst_active;

   demux_burst_sched #(.DATA_W(DATA_W), .BURST_LEN(BURST_LEN)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .mask(mask),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .cur_sel(cur_sel), .burst_active(burst_active)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      logic [2:0] ch;
   } word_t;

   typedef struct {
      logic       rst;
      logic [7:0] mask;
      logic       exp_rdy;
   } vec_t;

   word_t      stim_q[$];
   word_t      sb_q[$];
   vec_t       vecs[6];
   int         checks = 0;
   int         errors = 0;
   int         n_acc  = 0;
   int         stalls = 0;
   logic [7:0] seen_ch = 8'h00;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic drive();
      in_valid = (stim_q.size() > 0);
      in_data  = (stim_q.size() > 0) ? stim_q[0].data : 8'h00;
   endtask

   // One clock: sample at negedge (deliveries then accepts), then step past posedge.
   task automatic cyc();
      word_t w;
      @(negedge clk);
      if (!rst) begin
         seen_ch |= out_valid;
         chk("onehot", 32'($countones(out_valid) <= 1), 32'd1);
         if ((out_valid & out_ready) != 8'h00) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_delivery actual=%0h/%0h required=none", out_valid, out_data);
            end else begin
               w = sb_q.pop_front();
               chk("deliver_ch", 32'(out_valid), 32'(8'h01 << w.ch));
               chk("deliver_data", 32'(out_data), 32'(w.data));
            end
         end
         if (in_valid && in_ready) begin
            sb_q.push_back(stim_q.pop_front());
            n_acc++;
         end else if (in_valid) begin
            stalls++;
         end
      end
      @(posedge clk);
      #1;
      drive();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      stim_q.delete();
      sb_q.delete();
      drive();
      cyc();
      rst     = 1'b0;
      n_acc   = 0;
      stalls  = 0;
      seen_ch = 8'h00;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((stim_q.size() + sb_q.size()) > 0 && n < budget) begin
         cyc();
         n++;
      end
      chk("drain_left", 32'(stim_q.size() + sb_q.size()), 32'd0);
   endtask

   task automatic wait_acc(input int target, input int budget);
      int n = 0;
      while (n_acc < target && n < budget) begin
         cyc();
         n++;
      end
      chk("wait_accept", 32'(n_acc), 32'(target));
   endtask

   task automatic push(input logic [7:0] d, input logic [2:0] ch);
      word_t w;
      w.data = d;
      w.ch   = ch;
      stim_q.push_back(w);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{rst: 1'b0, mask: 8'hFF, exp_rdy: 1'b1};
      vecs[1] = '{rst: 1'b0, mask: 8'h00, exp_rdy: 1'b0};
      vecs[2] = '{rst: 1'b0, mask: 8'h10, exp_rdy: 1'b1};
      vecs[3] = '{rst: 1'b1, mask: 8'hFF, exp_rdy: 1'b0};
      vecs[4] = '{rst: 1'b0, mask: 8'h80, exp_rdy: 1'b1};
      vecs[5] = '{rst: 1'b1, mask: 8'h00, exp_rdy: 1'b0};

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      mask      = 8'h00;
      out_ready = 8'hFF;
      repeat (2) cyc();
      rst = 1'b0;
      chk("rst_out_valid", 32'(out_valid), 32'h00);
      chk("rst_out_data", 32'(out_data), 32'h00);
      chk("rst_cur_sel", 32'(cur_sel), 32'd0);
      chk("rst_burst_active", 32'(burst_active), 32'd0);

      // Idle vectors: in_ready follows mask, and rst forces it low
      for (int i = 0; i < 6; i++) begin
         rst  = vecs[i].rst;
         mask = vecs[i].mask;
         #1;
         chk("vec_in_ready", 32'(in_ready), 32'(vecs[i].exp_rdy));
         chk("vec_out_valid", 32'(out_valid), 32'h00);
         chk("vec_burst_active", 32'(burst_active), 32'd0);
         cyc();
      end
      rst = 1'b0;

      // Stream: 16 words, 4 per channel 0..3, one stall cycle between bursts
      do_reset();
      mask      = 8'hFF;
      out_ready = 8'hFF;
      for (int k = 0; k < 16; k++) push(8'(k), 3'(k / 4));
      drive();
      drain(200);
      chk("stream_accepts", 32'(n_acc), 32'd16);
      chk("stream_stalls", 32'(stalls), 32'd3);

      // Mask skip and wrap: channels 0, 7, 0
      do_reset();
      mask = 8'h81;
      for (int k = 0; k < 12; k++) push(8'(8'h20 + k), (k >= 4 && k < 8) ? 3'd7 : 3'd0);
      drive();
      drain(200);
      chk("wrap_seen_channels", 32'(seen_ch), 32'h81);

      // Backpressure on channel 0 for 5 cycles after the first word
      do_reset();
      mask      = 8'hFF;
      out_ready = 8'hFE;
      for (int k = 0; k < 4; k++) push(8'(k), 3'd0);
      drive();
      wait_acc(1, 20);
      repeat (5) begin
         chk("bp_out_valid", 32'(out_valid), 32'h01);
         chk("bp_out_data", 32'(out_data), 32'h00);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         cyc();
      end
      out_ready = 8'hFF;
      drain(100);
      chk("bp_accepts", 32'(n_acc), 32'd4);

      // Mid-burst disable of channel 2 after two words
      do_reset();
      mask = 8'hFC;
      push(8'h40, 3'd2);
      push(8'h41, 3'd2);
      push(8'h42, 3'd3);
      push(8'h43, 3'd3);
      drive();
      wait_acc(2, 20);
      mask = 8'hF8;
      drain(100);

      // Mask zero blocks everything; enabling channel 4 lets the word through
      do_reset();
      mask = 8'h00;
      push(8'h55, 3'd4);
      drive();
      repeat (10) begin
         cyc();
         chk("mz_in_ready", 32'(in_ready), 32'd0);
         chk("mz_out_valid", 32'(out_valid), 32'h00);
      end
      mask = 8'h10;
      drain(50);
      chk("mz_accepts", 32'(n_acc), 32'd1);

      // Reset while a word is held for channel 5
      do_reset();
      mask      = 8'h20;
      out_ready = 8'h00;
      push(8'h77, 3'd5);
      drive();
      wait_acc(1, 20);
      chk("mr_held_valid", 32'(out_valid), 32'h20);
      chk("mr_held_sel", 32'(cur_sel), 32'd5);
      rst = 1'b1;
      sb_q.delete();
      cyc();
      rst  = 1'b0;
      mask = 8'hFF;
      chk("mr_out_valid", 32'(out_valid), 32'h00);
      chk("mr_cur_sel", 32'(cur_sel), 32'd0);
      chk("mr_burst_active", 32'(burst_active), 32'd0);
      out_ready = 8'hFF;
      push(8'h99, 3'd0);
      drive();
      drain(50);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
